// File: rtl/r4_mult_pkg.sv
// r4_mult_pkg: shared FSM states and default timing for the
// byte-serial radix-4 multiplier driver.
package r4_mult_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        SGAP,
        A_STB,
        A_GAP,
        X_STB,
        X_GAP,
        WAIT_RDY,
        DONE
    } state_e;

    localparam int BYTE_W = 8;
    localparam int TMR_W  = 16;

    localparam int DEF_START_CYC   = 6;
    localparam int DEF_STB_CYC     = 6;
    localparam int DEF_GAP_CYC     = 6;
    localparam int DEF_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/r4_phase_timer.sv
// r4_phase_timer: loadable down-counter that times every phase
// of the driver (start pulse, strobes, gaps and ready timeout).
module r4_phase_timer
    import r4_mult_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         done,
    output logic         almost
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = len;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // almost flags the second-to-last clock of a phase
    assign done   = (cnt_q == '0);
    assign almost = (cnt_q == W'(1));

endmodule

// File: rtl/r4_mult_driver.sv
// r4_mult_driver: takes an operand pair, streams it bytewise into the
// radix-4 multiplier and hands the product back over valid/ready.
module r4_mult_driver
    import r4_mult_pkg::*;
#(
    parameter int OP_W        = 16,
    parameter int START_CYC   = DEF_START_CYC,
    parameter int STB_CYC     = DEF_STB_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_x,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*OP_W-1:0] res_data,
    output logic              res_err,
    output logic              mul_start,
    output logic              mul_getA,
    output logic              mul_getX,
    output logic [7:0]        mul_in,
    input  logic [2*OP_W-1:0] mul_result,
    input  logic              mul_ready,
    output logic              busy
);

    localparam int NB = OP_W / BYTE_W;
    localparam logic [7:0] LAST_IDX = 8'(NB - 1);

    localparam logic [TMR_W-1:0] LEN_START = TMR_W'(START_CYC - 1);
    localparam logic [TMR_W-1:0] LEN_STB   = TMR_W'(STB_CYC - 1);
    localparam logic [TMR_W-1:0] LEN_GAP   = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] LEN_TMO   = TMR_W'(TIMEOUT_CYC - 1);

    state_e state_q, state_d;

    logic [7:0]        idx_q, idx_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   x_q, x_d;
    logic              seen_q, seen_d;
    logic [7:0]        mul_in_q, mul_in_d;
    logic [2*OP_W-1:0] res_data_q, res_data_d;
    logic              res_err_q, res_err_d;
    logic              op_ready_q, op_ready_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic              get_a_q, get_a_d;
    logic              get_x_q, get_x_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_len;
    logic              tmr_done;
    logic              tmr_almost;

    logic              last_byte;
    logic [7:0]        idx_nxt;

    function automatic logic [BYTE_W-1:0] byte_of(
        input logic [OP_W-1:0] v,
        input logic [7:0]      i
    );
        return v[int'(i)*BYTE_W +: BYTE_W];
    endfunction

    r4_phase_timer #(.W(TMR_W)) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .len    (tmr_len),
        .done   (tmr_done),
        .almost (tmr_almost)
    );

    assign last_byte = (idx_q == LAST_IDX);
    assign idx_nxt   = idx_q + 8'd1;

    // next byte is put on mul_in in the last gap clock (needs GAP_CYC >= 2)
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        x_d        = x_q;
        seen_d     = seen_q;
        mul_in_d   = mul_in_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        tmr_load   = 1'b0;
        tmr_len    = '0;
        unique case (state_q)
            IDLE: begin
                if (op_valid && op_ready_q) begin
                    a_d      = op_a;
                    x_d      = op_x;
                    seen_d   = 1'b0;
                    idx_d    = '0;
                    state_d  = START;
                    tmr_load = 1'b1;
                    tmr_len  = LEN_START;
                end
            end
            START: begin
                if (tmr_done) begin
                    state_d  = SGAP;
                    tmr_load = 1'b1;
                    tmr_len  = LEN_GAP;
                end
            end
            SGAP: begin
                if (tmr_almost) begin
                    mul_in_d = byte_of(a_q, 8'd0);
                end
                if (tmr_done) begin
                    idx_d    = '0;
                    state_d  = A_STB;
                    tmr_load = 1'b1;
                    tmr_len  = LEN_STB;
                end
            end
            A_STB: begin
                if (tmr_done) begin
                    state_d  = A_GAP;
                    tmr_load = 1'b1;
                    tmr_len  = LEN_GAP;
                end
            end
            A_GAP: begin
                if (tmr_almost) begin
                    mul_in_d = last_byte ? byte_of(x_q, 8'd0)
                                         : byte_of(a_q, idx_nxt);
                end
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_len  = LEN_STB;
                    if (last_byte) begin
                        idx_d   = '0;
                        state_d = X_STB;
                    end else begin
                        idx_d   = idx_nxt;
                        state_d = A_STB;
                    end
                end
            end
            X_STB: begin
                if (tmr_done) begin
                    state_d  = X_GAP;
                    tmr_load = 1'b1;
                    tmr_len  = LEN_GAP;
                end
            end
            X_GAP: begin
                if (tmr_almost && !last_byte) begin
                    mul_in_d = byte_of(x_q, idx_nxt);
                end
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (last_byte) begin
                        state_d = WAIT_RDY;
                        tmr_len = LEN_TMO;
                    end else begin
                        idx_d   = idx_nxt;
                        state_d = X_STB;
                        tmr_len = LEN_STB;
                    end
                end
            end
            WAIT_RDY: begin
                // a ready left over from the previous product is ignored
                seen_d = seen_q | ~mul_ready;
                if (seen_q && mul_ready) begin
                    res_data_d = mul_result;
                    res_err_d  = 1'b0;
                    state_d    = DONE;
                end else if (tmr_done) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_valid_q && res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        op_ready_d  = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        start_d     = (state_d == START);
        get_a_d     = (state_d == A_STB);
        get_x_d     = (state_d == X_STB);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            x_q         <= '0;
            seen_q      <= 1'b0;
            mul_in_q    <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            get_a_q     <= 1'b0;
            get_x_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            x_q         <= x_d;
            seen_q      <= seen_d;
            mul_in_q    <= mul_in_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            get_a_q     <= get_a_d;
            get_x_q     <= get_x_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign busy      = busy_q;
    assign mul_start = start_q;
    assign mul_getA  = get_a_q;
    assign mul_getX  = get_x_q;
    assign mul_in    = mul_in_q;

endmodule

// File: tb/tb_r4_mult_driver.sv
// tb_r4_mult_driver: directed vectors against a behavioural radix-4
// multiplier model; strobe timing measured on falling edges.
module tb_r4_mult_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_x = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic        mul_start;
    logic        mul_getA;
    logic        mul_getX;
    logic [7:0]  mul_in;
    logic [31:0] mul_result = '0;
    logic        mul_ready = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    r4_mult_driver #(.TIMEOUT_CYC(50)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_x       (op_x),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .mul_start  (mul_start),
        .mul_getA   (mul_getA),
        .mul_getX   (mul_getX),
        .mul_in     (mul_in),
        .mul_result (mul_result),
        .mul_ready  (mul_ready),
        .busy       (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // multiplier model and strobe monitor
    int ncyc = 0, t_start = -1, t_rv = -1, lf = -1;
    int t_rise[4];
    int t_fall[4];
    int na = 0, nx = 0, hold_bad = 0, overlap_bad = 0;
    int mdl_mode = 0;
    logic [7:0] cap_a[2];
    logic [7:0] cap_x[2];
    logic p_start = 0, p_ga = 0, p_gx = 0, p_rv = 0;
    logic [7:0] p_in = '0;
    logic signed [31:0] ma, mx;

    always @(negedge clk) begin
        ncyc++;
        if ((mul_getA && mul_getX) || (mul_start && (mul_getA || mul_getX)))
            overlap_bad++;
        if ((mul_getA || mul_getX) && mul_in != p_in)
            hold_bad++;
        if (mul_start && !p_start) begin
            t_start = ncyc;
            na = 0;
            nx = 0;
            lf = -1;
            if (mdl_mode != 1) mul_ready = 1'b0;
        end
        if (mul_getA && !p_ga) begin
            if (na < 2) begin
                cap_a[na] = mul_in;
                t_rise[na] = ncyc;
            end
            na++;
        end
        if (!mul_getA && p_ga && na >= 1 && na <= 2)
            t_fall[na-1] = ncyc;
        if (mul_getX && !p_gx) begin
            if (nx < 2) begin
                cap_x[nx] = mul_in;
                t_rise[2+nx] = ncyc;
            end
            nx++;
        end
        if (!mul_getX && p_gx && nx >= 1 && nx <= 2) begin
            t_fall[1+nx] = ncyc;
            if (nx == 2) lf = ncyc;
        end
        if (res_valid && !p_rv) t_rv = ncyc;
        if (lf >= 0) begin
            ma = $signed({cap_a[1], cap_a[0]});
            mx = $signed({cap_x[1], cap_x[0]});
            if (mdl_mode == 0 && ncyc - lf == 20) begin
                mul_result = ma * mx;
                mul_ready  = 1'b1;
            end
            if (mdl_mode == 1 && ncyc - lf == 9)
                mul_ready = 1'b0;
            if (mdl_mode == 1 && ncyc - lf == 15) begin
                mul_result = ma * mx;
                mul_ready  = 1'b1;
            end
        end
        p_start = mul_start;
        p_ga    = mul_getA;
        p_gx    = mul_getX;
        p_rv    = res_valid;
        p_in    = mul_in;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] x);
        int k;
        op_a = a;
        op_x = x;
        op_valid = 1'b1;
        k = 0;
        while (!mul_start && k < 50) begin
            tick();
            k++;
        end
        op_valid = 1'b0;
        check("op_accept", {31'd0, mul_start}, 32'd1);
    endtask

    task automatic wait_rv(input int budget);
        int k;
        k = 0;
        while (!res_valid && k < budget) begin
            tick();
            k++;
        end
        check("rv_seen", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic take_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("rv_drop", {31'd0, res_valid}, 32'd0);
    endtask

    int bp_bad;
    int t0;
    int k;

    initial begin
        repeat (3) tick();
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res", {res_data[30:0], res_err}, 32'd0);
        check("rst_mul", {21'd0, mul_start, mul_getA, mul_getX, mul_in}, 32'd0);
        rst = 1'b1;
        tick();

        // basic: -5 * 8
        mdl_mode = 0;
        send_op(16'hFFFB, 16'h0008);
        check("busy_run", {30'd0, busy, op_ready}, 32'd2);
        wait_rv(200);
        check("basic_data", res_data, 32'hFFFFFFD8);
        check("basic_err", {31'd0, res_err}, 32'd0);
        check("byte_a0", {24'd0, cap_a[0]}, 32'hFB);
        check("byte_a1", {24'd0, cap_a[1]}, 32'hFF);
        check("byte_x0", {24'd0, cap_x[0]}, 32'h08);
        check("byte_x1", {24'd0, cap_x[1]}, 32'h00);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("rise%0d", s), t_rise[s] - t_start, 12 + 12 * s);
            check($sformatf("fall%0d", s), t_fall[s] - t_start, 18 + 12 * s);
        end

        // backpressure with a second op pending, then stale ready
        op_a = 16'd9;
        op_x = 16'd11;
        op_valid = 1'b1;
        mdl_mode = 1;
        bp_bad = 0;
        t0 = t_start;
        repeat (15) begin
            tick();
            if (res_data !== 32'hFFFFFFD8 || res_valid !== 1'b1 ||
                op_ready !== 1'b0 || t_start != t0)
                bp_bad++;
        end
        check("bp_hold", bp_bad, 0);
        res_ready = 1'b1;
        k = 0;
        tick();
        k++;
        res_ready = 1'b0;
        check("bp_rv_drop", {31'd0, res_valid}, 32'd0);
        while (!mul_start && k < 20) begin
            tick();
            k++;
        end
        op_valid = 1'b0;
        check("bp_accept_lat", k, 2);
        wait_rv(200);
        check("stale_data", res_data, 32'h00000063);
        check("stale_err", {31'd0, res_err}, 32'd0);
        take_res();

        // timeout
        mdl_mode = 2;
        send_op(16'h1234, 16'h0005);
        wait_rv(300);
        check("tmo_lat", t_rv - t_start, 110);
        check("tmo_err", {31'd0, res_err}, 32'd1);
        check("tmo_data", res_data, 32'd0);
        take_res();

        // reset during the second A strobe
        mdl_mode = 0;
        send_op(16'hFF12, 16'h0001);
        k = 0;
        while (na < 2 && k < 100) begin
            tick();
            k++;
        end
        tick();
        check("pre_rst_in", {24'd0, mul_in}, 32'hFF);
        check("pre_rst_geta", {31'd0, mul_getA}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_mul", {21'd0, mul_start, mul_getA, mul_getX, mul_in}, 32'd0);
        check("rst_mid_busy", {30'd0, busy, res_valid}, 32'd0);
        check("rst_mid_res", {res_data[30:0], res_err}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rel_op_ready", {31'd0, op_ready}, 32'd1);
        send_op(16'h0002, 16'h0003);
        wait_rv(200);
        check("post_rst_data", res_data, 32'h00000006);
        take_res();

        check("strobe_overlap", overlap_bad, 0);
        check("mul_in_hold", hold_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/r4_mult_driver.md
Name: r4_mult_driver

Overview:
- Host-side initiator for the byte-serial radix-4 multiplier (ASSUME_R4). It drives that block's start/getA/getX/in interface.
- Accepts a parallel 16-bit operand pair over a valid/ready handshake, then issues the start pulse and streams A and X bytes, low byte first.
- Waits for the multiplier's ready, then returns the 32-bit product over a valid/ready result handshake.
- Sits between the FPGA host logic (switch/UART front end) and the multiplier core.

Parameters:
- OP_W, 16, operand width; must be a multiple of 8 (byte count NB = OP_W/8).
- START_CYC, 6, width of the mul_start pulse in clocks.
- STB_CYC, 6, clocks each getA/getX strobe is held high per byte.
- GAP_CYC, 6, clocks with strobes low after start and after every byte.
- TIMEOUT_CYC, 1023, maximum clocks in WAIT_RDY before the block aborts.

Ports:
- clk  in  1  system clock; all flops on its rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- op_valid  in  1  operand pair offered.
- op_ready  out  1  block can accept an operand pair.
- op_a  in  OP_W  multiplicand, two's complement.
- op_x  in  OP_W  multiplier, two's complement.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  2*OP_W  captured product.
- res_err  out  1  result aborted by timeout; res_data is 0.
- mul_start  out  1  start pulse to the multiplier.
- mul_getA  out  1  A-byte load strobe.
- mul_getX  out  1  X-byte load strobe.
- mul_in  out  8  byte bus to the multiplier.
- mul_result  in  2*OP_W  multiplier product.
- mul_ready  in  1  multiplier done flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, any time, including mid-transfer):
  - state=IDLE; every counter cleared.
  - op_ready=1, res_valid=0, res_err=0, res_data=0, busy=0.
  - mul_start=0, mul_getA=0, mul_getX=0, mul_in=0.
  - After reset is released, the multiplier starts clean because the next operation begins with a start pulse.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - op_ready=1.
  - When op_valid & op_ready, latch op_a/op_x into shadow registers, clear seen_low, go to START.
- START: mul_start=1 for START_CYC clocks, then go to SGAP.
- SGAP: all strobes low for GAP_CYC clocks; byte index i=0; go to A_STB.
- A_STB:
  - mul_in = byte i of A; mul_getA=1 for STB_CYC clocks.
  - mul_in is driven one clock before the strobe rises, and is held through the strobe and the following gap.
  - Go to A_GAP.
- A_GAP: strobes low for GAP_CYC clocks. Then i++; if i<NB go to A_STB, else i=0 and go to X_STB.
- X_STB / X_GAP: identical to A_STB/A_GAP, using mul_getX and the X bytes. After the last X byte's gap, go to WAIT_RDY.
- mul_getA and mul_getX are never high together. mul_start is never high together with either strobe.
- WAIT_RDY:
  - Set seen_low when mul_ready=0 is sampled (a stale ready from the prior operation is ignored).
  - When seen_low & mul_ready: capture mul_result into res_data, set res_err=0, go to DONE.
  - When the timeout counter reaches TIMEOUT_CYC: res_data=0, res_err=1, go to DONE.
- DONE:
  - res_valid=1, op_ready=0.
  - res_data and res_err are held stable until res_valid & res_ready.
  - On that handshake the next clock is IDLE with res_valid=0.
- op_ready is 0 in all states except IDLE. A new op_valid arriving while busy is not taken and stays pending at the source.
- Simultaneous events:
  - res_ready high in the same cycle DONE is entered is honoured on the following clock (DONE lasts at least 1 cycle).
  - mul_ready and the timeout asserting together: success wins.
- Fixed latency, op handshake to WAIT_RDY entry: START_CYC + GAP_CYC + 2*NB*(STB_CYC+GAP_CYC) clocks. With defaults this is 6+6+48 = 60.
- Result width is 2*OP_W. No sign manipulation: the product is passed through untouched.

Decomposition:
- Package r4_mult_pkg:
  - state enum: IDLE, START, SGAP, A_STB, A_GAP, X_STB, X_GAP, WAIT_RDY, DONE.
  - Default timing constants (START_CYC, STB_CYC, GAP_CYC, TIMEOUT_CYC).
  - Byte-width constant 8.
- One sub-module, r4_phase_timer:
  - Loadable down-counter with inputs load/len and output done.
  - Reused for START, STB, GAP and timeout counting.
- The FSM, byte mux and result register stay in r4_mult_driver.

Test Plan:
- Basic multiply:
  - Stimulus: op_a=0xFFFB, op_x=0x0008, defaults; behavioural multiplier model asserts ready 20 clocks after the last byte.
  - Response: bytes FB,FF on getA, then 08,00 on getX, each strobe 6 clocks with 6-clock gaps; res_data=0xFFFFFFD8, res_err=0.
- Timing check:
  - Stimulus: same run, with cycle-counted strobe edges checked.
  - Response: first getA rises exactly 12 clocks after mul_start rises; WAIT_RDY is entered at 60; getA/getX/start are never concurrent.
- Stale ready:
  - Stimulus: model holds mul_ready=1 from the previous op, drops it 3 clocks into WAIT_RDY, and raises it again with 0x00000063 for op_a=9, op_x=11.
  - Response: the old value is not captured; res_data=0x63.
- Backpressure:
  - Stimulus: res_ready=0 for 15 clocks after res_valid, and a second op_valid is held meanwhile.
  - Response: res_data stays stable, op_ready=0; the second op is accepted only after the result handshake.
- Timeout:
  - Stimulus: model never asserts ready, TIMEOUT_CYC=50.
  - Response: res_valid with res_err=1 and res_data=0 exactly 50 clocks after WAIT_RDY entry.
- Mid-operation reset:
  - Stimulus: pulse rst=0 during the second A_STB (mul_in=0xFF).
  - Response: all outputs are 0 at once; op_ready=1 after release. A new op 0x0002×0x0003 then yields 0x00000006.
